// File: rtl/spi_burst_pkg.sv
// Shared types and helpers for the BMP280 burst SPI master.
package spi_burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_TRAIL = 2'd3
   } state_e;

   localparam int SPI_MODE0 = 0;
   localparam int SPI_MODE3 = 3;

   function automatic int len_w(input int max_bytes);
      return $clog2(max_bytes + 1);
   endfunction

endpackage

// File: rtl/spi_burst_master_clk_gen.sv
// SCK half-period counter: phase_tick_o pulses every CLK_DIV cycles while not held in restart.
module spi_clk_gen #(
   parameter int CLK_DIV = 6
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   output logic phase_tick_o
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign phase_tick_o = !restart_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i || phase_tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/spi_burst_master.sv
// Burst SPI master (mode 0/3): one {rw,addr} byte then up to MAX_BYTES data bytes.
// Define SPI_BURST_DEBUG_EN to mirror the FSM state on debug_states.
module spi_burst_master
   import spi_burst_pkg::*;
#(
   parameter int  CLK_DIV   = 6,
   parameter int  SPI_MODE  = SPI_MODE0,
   parameter int  MAX_BYTES = 8,
   localparam int LEN_W     = len_w(MAX_BYTES)
) (
   input  logic             clk12MHz,
   input  logic             rst,
   input  logic             go,
   input  logic             rw,
   input  logic [6:0]       addr,
   input  logic [LEN_W-1:0] len,
   input  logic [7:0]       tx_data,
   output logic             tx_ack,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             done,
   output logic             csb,
   output logic             sck,
   output logic             sdo,
   input  logic             sdi,
   output logic [3:0]       debug_states
);

   localparam logic             SCK_IDLE = (SPI_MODE == SPI_MODE3);
   localparam int               BW       = LEN_W + 3;
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BYTES);

   state_e           state_q;
   logic             go_q, rw_q, hi_q;
   logic [6:0]       addr_q, tx_sh_q, rx_sh_q;
   logic [LEN_W-1:0] len_q, len_d;
   logic [BW-1:0]    bit_q, last_bit;
   logic             csb_q, sck_q, sdo_q, busy_q, done_q, tx_ack_q, rx_valid_q;
   logic [7:0]       rx_data_q;
   logic             start_d, restart, tick, in_data;

   assign len_d    = (len > MAX_LEN) ? MAX_LEN : len;
   assign last_bit = {len_q, 3'b111};
   assign in_data  = (bit_q[BW-1:3] != '0);
   assign restart  = (state_q == ST_IDLE);
   // go is ignored while busy, in the done cycle, and in the cycle already accepted
   assign start_d  = (state_q == ST_IDLE) && go && !done_q && !go_q;

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk_i       (clk12MHz),
      .rst_i       (rst),
      .restart_i   (restart),
      .phase_tick_o(tick)
   );

   always_ff @(posedge clk12MHz) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         go_q       <= 1'b0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         bit_q      <= '0;
         hi_q       <= 1'b0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         csb_q      <= 1'b1;
         sck_q      <= SCK_IDLE;
         sdo_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tx_ack_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         done_q     <= 1'b0;
         tx_ack_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         go_q       <= start_d;
         if (start_d) begin
            rw_q   <= rw;
            addr_q <= addr;
            len_q  <= len_d;
         end
         case (state_q)
            ST_IDLE: if (go_q) begin
               state_q <= ST_LEAD;
               csb_q   <= 1'b0;
               busy_q  <= 1'b1;
               sdo_q   <= rw_q;
               tx_sh_q <= addr_q;
               bit_q   <= '0;
               hi_q    <= 1'b0;
            end
            ST_LEAD: if (tick) begin
               state_q <= ST_SHIFT;
               sck_q   <= 1'b0;
            end
            ST_SHIFT: if (tick) begin
               if (!hi_q) begin
                  sck_q <= 1'b1;
                  hi_q  <= 1'b1;
                  if (in_data) begin
                     rx_sh_q <= {rx_sh_q[5:0], sdi};
                     if (rw_q && bit_q[2:0] == 3'd7) begin
                        rx_data_q  <= {rx_sh_q, sdi};
                        rx_valid_q <= 1'b1;
                     end
                  end
               end else if (bit_q == last_bit) begin
                  state_q <= ST_TRAIL;
                  sck_q   <= SCK_IDLE;
               end else begin
                  sck_q <= 1'b0;
                  hi_q  <= 1'b0;
                  bit_q <= bit_q + 1'b1;
                  // falling edge opening a data byte: reload from upstream or hold sdo low
                  if (bit_q[2:0] == 3'd7) begin
                     if (rw_q) begin
                        tx_sh_q <= '0;
                        sdo_q   <= 1'b0;
                     end else begin
                        tx_sh_q  <= tx_data[6:0];
                        sdo_q    <= tx_data[7];
                        tx_ack_q <= 1'b1;
                     end
                  end else begin
                     tx_sh_q <= {tx_sh_q[5:0], 1'b0};
                     sdo_q   <= tx_sh_q[6];
                  end
               end
            end
            ST_TRAIL: if (tick) begin
               state_q <= ST_IDLE;
               csb_q   <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               sdo_q   <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign csb      = csb_q;
   assign sck      = sck_q;
   assign sdo      = sdo_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign tx_ack   = tx_ack_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;

`ifdef SPI_BURST_DEBUG_EN
   assign debug_states = {2'b00, state_q};
`else
   assign debug_states = 4'b0000;
`endif

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench: two masters (mode 0 / CLK_DIV 6 and mode 3 / CLK_DIV 2) against a byte-level model.
module tb_spi_burst_master;

   localparam int MAXB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst[2], go[2], rw[2], sdi[2];
   logic       tx_ack[2], rx_valid[2], busy[2], done[2], csb[2], sck[2], sdo[2];
   logic [6:0] addr[2];
   logic [3:0] len[2];
   logic [7:0] tx_data[2], rx_data[2];
   logic [3:0] dbg[2];

   spi_burst_master #(.CLK_DIV(6), .SPI_MODE(0), .MAX_BYTES(MAXB)) u_a (
      .clk12MHz(clk), .rst(rst[0]), .go(go[0]), .rw(rw[0]), .addr(addr[0]), .len(len[0]),
      .tx_data(tx_data[0]), .tx_ack(tx_ack[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
      .busy(busy[0]), .done(done[0]), .csb(csb[0]), .sck(sck[0]), .sdo(sdo[0]), .sdi(sdi[0]),
      .debug_states(dbg[0]));

   spi_burst_master #(.CLK_DIV(2), .SPI_MODE(3), .MAX_BYTES(MAXB)) u_b (
      .clk12MHz(clk), .rst(rst[1]), .go(go[1]), .rw(rw[1]), .addr(addr[1]), .len(len[1]),
      .tx_data(tx_data[1]), .tx_ack(tx_ack[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
      .busy(busy[1]), .done(done[1]), .csb(csb[1]), .sck(sck[1]), .sdo(sdo[1]), .sdi(sdi[1]),
      .debug_states(dbg[1]));

   int checks = 0, failures = 0;

   // observation state for the currently active master
   int   act, t0, csb_fall_t, csb_rise_t, first_fall, last_fall, csb_fall_n;
   logic prev_csb, prev_sck;
   int   rise_t[$], ack_t[$], rx_t[$], done_t[$];
   logic sdo_bits[$];
   logic [7:0] rx_v[$];
   logic [7:0] wr_b[16], rd_b[16];
   logic sl_bits[128];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mon();
      if (prev_csb && !csb[act]) begin csb_fall_t = cyc; csb_fall_n++; end
      if (!prev_csb && csb[act]) csb_rise_t = cyc;
      if (!prev_sck && sck[act]) begin rise_t.push_back(cyc); sdo_bits.push_back(sdo[act]); end
      if (prev_sck && !sck[act]) begin
         if (first_fall < 0) first_fall = cyc;
         last_fall = cyc;
      end
      if (tx_ack[act]) ack_t.push_back(cyc);
      if (rx_valid[act]) begin rx_t.push_back(cyc); rx_v.push_back(rx_data[act]); end
      if (done[act]) done_t.push_back(cyc);
      prev_csb = csb[act];
      prev_sck = sck[act];
      tx_data[act] = (ack_t.size() < 16) ? wr_b[ack_t.size()] : 8'h00;
      sdi[act] = (rise_t.size() < 128) ? sl_bits[rise_t.size()] : 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      mon();
   endtask

   task automatic start_mon(input int d, input int l);
      act = d;
      rise_t.delete(); ack_t.delete(); rx_t.delete(); done_t.delete();
      sdo_bits.delete(); rx_v.delete();
      csb_fall_t = -1; csb_rise_t = -1; first_fall = -1; last_fall = -1; csb_fall_n = 0;
      prev_csb = csb[d];
      prev_sck = sck[d];
      for (int i = 0; i < 128; i++) sl_bits[i] = 1'($urandom);
      for (int k = 0; k < l; k++)
         for (int b = 0; b < 8; b++) sl_bits[8 + 8*k + b] = rd_b[k][7-b];
      tx_data[d] = wr_b[0];
      sdi[d] = sl_bits[0];
   endtask

   task automatic fill_random();
      for (int i = 0; i < 16; i++) begin
         wr_b[i] = 8'($urandom);
         rd_b[i] = 8'($urandom);
      end
   endtask

   task automatic xfer(input int d, input bit r, input logic [6:0] a, input int ln);
      int l, dv, lim;
      logic [7:0] ob, eb;
      l  = (ln > MAXB) ? MAXB : ln;
      dv = (d == 0) ? 6 : 2;
      start_mon(d, l);
      rw[d] = r; addr[d] = a; len[d] = 4'(ln); go[d] = 1'b1;
      t0 = cyc + 1;
      step();
      go[d] = 1'b0;
      for (lim = 0; lim < 4000 && done_t.size() == 0; lim++) step();
      chk("done_seen", done_t.size(), 1);
      if (done_t.size() == 0) return;
      step(); step();
      chk("done_edge", done_t[0] - t0, 1 + dv*(2 + 16*(1 + l)));
      chk("csb_fall_edge", csb_fall_t - t0, 1);
      chk("csb_rise_at_done", csb_rise_t, done_t[0]);
      chk("sck_rises", rise_t.size(), 8*(1 + l));
      if (sdo_bits.size() == 8*(1 + l))
         for (int k = 0; k <= l; k++) begin
            for (int b = 0; b < 8; b++) ob[7-b] = sdo_bits[8*k + b];
            eb = (k == 0) ? {r, a} : (r ? 8'h00 : wr_b[k-1]);
            chk($sformatf("sdo_byte%0d", k), ob, eb);
         end
      chk("tx_ack_count", ack_t.size(), r ? 0 : l);
      if (!r && l > 0 && ack_t.size() > 0) chk("tx_ack1_edge", ack_t[0] - t0, 1 + dv*17);
      chk("rx_valid_count", rx_v.size(), r ? l : 0);
      if (r && rx_v.size() == l) begin
         for (int k = 0; k < l; k++) chk($sformatf("rx_byte%0d", k + 1), rx_v[k], rd_b[k]);
         if (l > 0) chk("rx1_edge", rx_t[0] - t0, 1 + dv*32);
      end
      chk("sck_idle_after", sck[d], d == 1);
      chk("csb_high_after", csb[d], 1'b1);
      chk("busy_low_after", busy[d], 1'b0);
   endtask

   initial begin
      int lim, d, ln, dbg_exp;
      bit r;
      logic [6:0] a;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; go[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; len[i] = '0;
         tx_data[i] = '0; sdi[i] = 1'b0;
      end
      act = 0; prev_csb = 1'b1; prev_sck = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++)
         chk($sformatf("reset_state_dut%0d", i),
             {csb[i], sck[i], sdo[i], busy[i], done[i], tx_ack[i], rx_valid[i], rx_data[i], dbg[i]},
             {1'b1, i == 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0});
      rst[0] = 1'b0; rst[1] = 1'b0;
      repeat (2) @(negedge clk);

      // mode 0 write, addr 0x74, one byte 0x27
      fill_random();
      wr_b[0] = 8'h27;
      xfer(0, 1'b0, 7'h74, 1);
      if (ack_t.size() > 0) chk("write_ack_edge103", ack_t[0] - t0, 103);
      if (done_t.size() > 0) chk("write_done_edge205", done_t[0] - t0, 205);
      chk("mode0_csb_hold", csb_rise_t - last_fall, 6);

      // mode 3 read, addr 0x7A, three bytes from the slave
      fill_random();
      rd_b[0] = 8'h80; rd_b[1] = 8'h00; rd_b[2] = 8'h55;
      xfer(1, 1'b1, 7'h7A, 3);
      chk("mode3_csb_setup", first_fall - csb_fall_t, 2);
      if (rise_t.size() > 1) chk("sck_period_div2", rise_t[1] - rise_t[0], 4);

      // address-only and clamped length
      fill_random();
      xfer(0, 1'b0, 7'($urandom), 0);
      fill_random();
      xfer(1, 1'b1, 7'($urandom), 0);
      fill_random();
      xfer(0, 1'b0, 7'($urandom), MAXB + 3);
      fill_random();
      xfer(1, 1'b1, 7'($urandom), 15);

      // go held high across a whole burst, then reset in the middle of the next one
      fill_random();
      start_mon(0, 2);
      rw[0] = 1'b0; addr[0] = 7'h15; len[0] = 4'd2; go[0] = 1'b1;
      t0 = cyc + 1;
      for (lim = 0; lim < 4000 && done_t.size() == 0; lim++) step();
      chk("held_go_first_done", done_t.size(), 1);
      if (done_t.size() > 0) begin
         chk("held_go_done_edge", done_t[0] - t0, 1 + 6*(2 + 16*3));
         chk("held_go_one_burst", csb_fall_n, 1);
         for (lim = 0; lim < 10 && csb_fall_n < 2; lim++) step();
         chk("held_go_restart_edge", csb_fall_t - done_t[0], 3);
      end
      go[0] = 1'b0;
      for (lim = 0; lim < 4000 && rise_t.size() < 24 + 10; lim++) step();
      chk("second_burst_shifting", rise_t.size() >= 34, 1'b1);
`ifdef SPI_BURST_DEBUG_EN
      dbg_exp = 2;
`else
      dbg_exp = 0;
`endif
      chk("debug_states_shift", dbg[0], 4'(dbg_exp));
      rst[0] = 1'b1;
      step();
      chk("midreset_outputs",
          {csb[0], sck[0], sdo[0], busy[0], done[0], tx_ack[0], rx_valid[0], rx_data[0], dbg[0]},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0});
      rst[0] = 1'b0;
      repeat (100) step();
      chk("midreset_no_done", done_t.size(), 1);

      // randomized bursts on both masters
      for (int t = 0; t < 8; t++) begin
         fill_random();
         d  = int'($urandom_range(0, 1));
         r  = 1'($urandom);
         a  = 7'($urandom);
         ln = int'($urandom_range(0, 15));
         xfer(d, r, a, ln);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_burst_master.md
# spi_burst_master

Parametrised SPI master for the BMP280 sensor path. It supports mode 0 and mode 3, a programmable SCK divider, and burst transfers of one address byte plus up to MAX_BYTES data bytes. It replaces the fixed 16-bit single-message SPI block with a byte-streaming read/write interface. It sits between the sensor-control FSM (go/addr/len, byte streams) and the BMP280 pins (csb, sck, sdo, sdi).

## Interface
Parameters:
- CLK_DIV, 6: clk12MHz cycles per SCK half-period; minimum 2. The default gives 1 MHz SCK.
- SPI_MODE, 0: SPI mode, 0 (SCK idles low) or 3 (SCK idles high); any other value is illegal.
- MAX_BYTES, 8: maximum data bytes per burst; LEN_W = $clog2(MAX_BYTES+1).

Ports:
- clk12MHz  in  1  system clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE.
- rw  in  1  1 = read burst, 0 = write burst; latched on go.
- addr  in  7  register address; latched on go.
- len  in  LEN_W  data byte count; latched on go; values above MAX_BYTES clamp to MAX_BYTES.
- tx_data  in  8  next write byte; must be stable whenever tx_ack can fire.
- tx_ack  out  1  one-cycle pulse when tx_data is loaded into the shifter.
- rx_data  out  8  last received byte; held until the next byte completes.
- rx_valid  out  1  one-cycle pulse, one per received data byte.
- busy  out  1  high from CSB fall through CSB rise.
- done  out  1  one-cycle pulse coincident with CSB rise.
- csb  out  1  chip select, active low.
- sck  out  1  serial clock.
- sdo  out  1  master out; MSB first.
- sdi  in  1  master in.
- debug_states  out  4  FSM state encoding (see Configuration).

## Operation
- Reset values: csb=1, sck=SPI_MODE==3, sdo=0, busy=0, done=0, tx_ack=0, rx_valid=0, rx_data=0, debug_states=0. FSM is in IDLE.
- FSM states: IDLE → LEAD → SHIFT → TRAIL → IDLE. Encodings are IDLE=0, LEAD=1, SHIFT=2, TRAIL=3.
- IDLE: when go=1, the block latches rw, addr and clamped len, drives csb to 0, raises busy and loads the shifter with {rw, addr}. sdo carries bit 7 of that byte from the CSB fall onward.
- LEAD: holds for CLK_DIV cycles with SCK at its idle level.
- SHIFT: transfers N = 8*(1+len) bits. Each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles, in both modes.
  - sdi is sampled on each SCK rising edge.
  - sdo changes only on the falling edge that opens a new bit. In mode 3, the first falling edge does not shift.
- Byte boundary, write burst: at the falling edge opening the first bit of data byte k, tx_data is loaded and tx_ack pulses. The upstream logic presents byte k+1 after each ack.
- Byte boundary, read burst: sdo is held at 0 during data bytes, and sdi is ignored during the address byte. At the SCK rising edge of bit 8 of each data byte, rx_data is updated and rx_valid pulses in the same cycle.
- TRAIL: after the last high phase, SCK returns to its idle level (mode 0 falls here) for CLK_DIV cycles. Then csb=1, busy=0, done pulses, and the FSM returns to IDLE.
- len=0: address-only transfer of 8 bits; no tx_ack, no rx_valid.
- go while busy is ignored; go on the cycle done pulses is also ignored.
- rst mid-transfer: on the next edge all outputs take their reset values (csb high, sck idle). No done pulse is issued and the partial rx byte is discarded.

## Timing
- go sampled at edge 0 → csb low and busy high at edge 1.
- CSB rise and done occur at edge 1 + CLK_DIV*(2 + 2N).
- Defaults with len=1: N=16, so done arrives at edge 205.
- tx_ack for byte 1 occurs at edge 1 + CLK_DIV*(1 + 16). rx_valid for byte k occurs at edge 1 + CLK_DIV*(1 + 16k + 15).

## Configuration
- SPI_BURST_DEBUG_EN:
  - Defined: debug_states mirrors the FSM encoding every cycle.
  - Undefined: debug_states is tied to 4'b0000 and the mirror logic is removed.
- Functional behaviour is otherwise identical.

## Structure
- Shared package spi_burst_pkg holds the state encodings, the mode constants (SPI_MODE0=0, SPI_MODE3=3) and the LEN_W function.
- One sub-module, spi_clk_gen, is the CLK_DIV half-period counter. It emits phase_tick pulses and is restartable from the FSM.

## Test plan
- Write, mode 0, defaults, addr=7'h74, len=1, tx_data=8'h27 → sdo carries 8'h74 then 8'h27; one tx_ack at edge 103; done at edge 205; sck idles low.
- Read, mode 3, addr=7'h7A, len=3, slave model returns 8'h80, 8'h00, 8'h55 → sdo address byte is 8'hFA; three rx_valid pulses with those values; sck idles high.
- len=0 → exactly 8 SCK rising edges, no tx_ack or rx_valid, done at edge 1 + CLK_DIV*18.
- len=MAX_BYTES+3 → clamped to MAX_BYTES; SCK rising-edge count is 8*(1+MAX_BYTES).
- go held high across a whole transfer → only one burst until after done; rst asserted mid-SHIFT → csb=1 and sck idle on the next edge, with no done pulse.
- CLK_DIV=2 → measured SCK period is 4 cycles; CSB setup and hold are each 2 cycles.
